lin_sched: RTL and testbench
============================

LIN_SCHED -- requirements
Module: lin_sched

Interface
REQ-001 Parameter: N_SLOTS, default 8, number of schedule-table entries (power of two).
REQ-002 Parameter: LEN_W, default 16, slot-length width in sys_clk cycles.
REQ-003 Parameter: MIN_LEN, default 32, minimum slot length; a shorter programmed length is clamped to this value.
REQ-004 sys_clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 en  in  1  schedule enable.
REQ-007 num_slots  in  $clog2(N_SLOTS)+1  active table length; 0 SHALL mean the schedule is stopped; values above N_SLOTS SHALL be treated as N_SLOTS.
REQ-008 cfg_we  in  1  table write strobe.
REQ-009 cfg_addr  in  $clog2(N_SLOTS)  table entry index.
REQ-010 cfg_pid  in  6  protected-ID field for the entry.
REQ-011 cfg_len  in  LEN_W  slot length for the entry, in cycles.
REQ-012 comm_busy  in  1  commander busy; a frame SHALL NOT be issued while this is high.
REQ-013 resp_tx_done  in  1  single-cycle pulse: responder completed the frame.
REQ-014 start  out  1  single-cycle frame-start pulse to the commander.
REQ-015 pid  out  6  ID of the current frame, held stable from the start pulse until the next start pulse.
REQ-016 slot_idx  out  $clog2(N_SLOTS)  index of the current or most recent slot.
REQ-017 frame_ok  out  1  single-cycle pulse: frame completed inside its slot.
REQ-018 frame_timeout  out  1  single-cycle pulse: slot expired without resp_tx_done.
REQ-019 sched_active  out  1  high in every state except IDLE.

Function
REQ-020 Table write: when cfg_we is high, entry[cfg_addr] SHALL take {cfg_pid, cfg_len} at the clock edge; writes are legal in any state.
REQ-021 The entry pid and length SHALL be latched in the ISSUE cycle, so a write to the active slot takes effect on its next visit.
REQ-022 States: IDLE, ISSUE, WAIT_RESP, WAIT_SLOT.
REQ-023 IDLE -> ISSUE with slot_idx=0 when en=1 and num_slots!=0; otherwise remain in IDLE.
REQ-024 ISSUE: while comm_busy=1, stay in ISSUE with start=0.
REQ-025 ISSUE with comm_busy=0: start=1 for exactly that cycle, load pid and the slot counter, then go to WAIT_RESP.
REQ-026 Slot timing: the cycle of the start pulse is slot cycle 0; the slot ends at cycle max(len,MIN_LEN)-1, so back-to-back start pulses are exactly max(len,MIN_LEN) cycles apart when comm_busy stays low.
REQ-027 WAIT_RESP: a resp_tx_done pulse SHALL produce frame_ok=1 in the next cycle and move to WAIT_SLOT.
REQ-028 WAIT_RESP: reaching the last slot cycle without resp_tx_done SHALL produce frame_timeout=1 in that cycle and advance.
REQ-029 resp_tx_done in the last slot cycle SHALL count as frame_ok, with no timeout.
REQ-030 resp_tx_done outside WAIT_RESP SHALL be ignored.
REQ-031 WAIT_SLOT: at the last slot cycle, advance.
REQ-032 Advance: slot_idx <= 0 if slot_idx+1 >= num_slots (wrap-around, including a shrink of num_slots while running), else slot_idx+1.
REQ-033 Advance: next state is ISSUE if en=1 and num_slots!=0, else IDLE.
REQ-034 Deasserting en mid-slot SHALL let the current slot run to its end, then enter IDLE with no further start pulse.
REQ-035 frame_ok and frame_timeout SHALL never be high in the same cycle; at most one of them per slot.

Reset
REQ-036 rst=1 SHALL immediately force state IDLE; start, pid, slot_idx, frame_ok, frame_timeout and sched_active to 0; slot counter to 0; all table entries to pid=0, len=0.
REQ-037 Reset asserted mid-frame SHALL abort the slot with no frame_ok or frame_timeout pulse.
REQ-038 After rst deasserts, the first start pulse SHALL occur no earlier than the second rising edge.

Verification
REQ-039 Table {0:(0x10,100), 1:(0x21,200)}, num_slots=2, en=1, resp_tx_done 40 cycles after each start -> start at T, T+100, T+300, T+400; pid sequence 0x10, 0x21, 0x10, 0x21; frame_ok once per slot.
REQ-040 Entry 0 = (0x05,64), num_slots=1, resp_tx_done never driven -> frame_timeout at T+63 and start again at T+64, repeating; frame_ok never asserted.
REQ-041 comm_busy held high for 50 cycles at slot start -> start delayed until the first cycle with comm_busy=0; next start is len cycles after the delayed start.
REQ-042 Entry len=10 -> start pulses 32 cycles apart (MIN_LEN clamp); resp_tx_done at the slot's last cycle -> frame_ok, no frame_timeout.
REQ-043 en dropped 20 cycles into a 100-cycle slot -> no further start; sched_active falls after slot cycle 99; num_slots reduced 4 -> 2 while slot_idx=3 -> next slot_idx=0.
REQ-044 rst pulsed during WAIT_RESP -> all outputs 0 in the same cycle, table reads zero, no pulse on frame_ok or frame_timeout.

Source files
------------

// File: rtl/lin_sched.sv
// LIN schedule-table master: walks a programmable table of (pid, slot length)
// entries, issuing one frame per slot and reporting completion or timeout.
module lin_sched #(
  parameter int N_SLOTS = 8,
  parameter int LEN_W   = 16,
  parameter int MIN_LEN = 32
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [$clog2(N_SLOTS):0]   num_slots,
  input  logic                       cfg_we,
  input  logic [$clog2(N_SLOTS)-1:0] cfg_addr,
  input  logic [5:0]                 cfg_pid,
  input  logic [LEN_W-1:0]           cfg_len,
  input  logic                       comm_busy,
  input  logic                       resp_tx_done,
  output logic                       start,
  output logic [5:0]                 pid,
  output logic [$clog2(N_SLOTS)-1:0] slot_idx,
  output logic                       frame_ok,
  output logic                       frame_timeout,
  output logic                       sched_active
);

  localparam int AW = $clog2(N_SLOTS);
  localparam logic [AW:0]      A_ONE = 1;
  localparam logic [AW:0]      A_MAX = N_SLOTS[AW:0];
  localparam logic [LEN_W-1:0] L_ONE = 1;
  localparam logic [LEN_W-1:0] L_MIN = MIN_LEN[LEN_W-1:0];

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP,
    WAIT_SLOT
  } state_t;

  state_t           r_state;
  logic [5:0]       r_tbl_pid [N_SLOTS];
  logic [LEN_W-1:0] r_tbl_len [N_SLOTS];
  logic [5:0]       r_pid;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_end;
  logic [AW-1:0]    r_idx;
  logic             r_ok;

  logic             w_go;
  logic [AW:0]      w_num;
  logic [AW:0]      w_idx_p1;
  logic [AW-1:0]    w_idx_nxt;
  logic [LEN_W-1:0] w_len;
  logic [LEN_W-1:0] w_len_c;
  logic             w_issue;
  logic             w_last;
  logic             w_adv;

  assign w_go      = en && (num_slots != '0);
  assign w_num     = (num_slots > A_MAX) ? A_MAX : num_slots;
  assign w_idx_p1  = {1'b0, r_idx} + A_ONE;
  assign w_idx_nxt = (w_idx_p1 >= w_num) ? '0 : w_idx_p1[AW-1:0];
  assign w_len     = r_tbl_len[r_idx];
  assign w_len_c   = (w_len < L_MIN) ? L_MIN : w_len;
  assign w_issue   = (r_state == ISSUE) && !comm_busy;
  assign w_last    = (r_cnt == r_end);
  assign w_adv     = ((r_state == WAIT_RESP) || (r_state == WAIT_SLOT))
                     && w_last;

  // The start cycle is slot cycle 0, so start and its pid come straight
  // from the ISSUE decision to keep slot periods exact.
  assign start         = w_issue;
  assign pid           = w_issue ? r_tbl_pid[r_idx] : r_pid;
  assign slot_idx      = r_idx;
  assign frame_ok      = r_ok;
  assign frame_timeout = (r_state == WAIT_RESP) && w_last && !resp_tx_done;
  assign sched_active  = (r_state != IDLE);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pid   <= '0;
      r_cnt   <= '0;
      r_end   <= '0;
      r_idx   <= '0;
      r_ok    <= 1'b0;
      for (int i = 0; i < N_SLOTS; i++) begin
        r_tbl_pid[i] <= '0;
        r_tbl_len[i] <= '0;
      end
    end else begin
      r_ok <= 1'b0;
      if (cfg_we) begin
        r_tbl_pid[cfg_addr] <= cfg_pid;
        r_tbl_len[cfg_addr] <= cfg_len;
      end
      case (r_state)
        IDLE: begin
          if (w_go) begin
            r_state <= ISSUE;
            r_idx   <= '0;
          end
        end
        ISSUE: begin
          if (!comm_busy) begin
            r_pid   <= r_tbl_pid[r_idx];
            r_end   <= w_len_c - L_ONE;
            r_cnt   <= L_ONE;
            r_state <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          r_cnt <= r_cnt + L_ONE;
          if (resp_tx_done) begin
            r_ok    <= 1'b1;
            r_state <= WAIT_SLOT;
          end
        end
        WAIT_SLOT: r_cnt <= r_cnt + L_ONE;
        default:   r_state <= IDLE;
      endcase
      // End of slot overrides the per-state updates above.
      if (w_adv) begin
        r_idx   <= w_idx_nxt;
        r_cnt   <= '0;
        r_state <= w_go ? ISSUE : IDLE;
      end
    end
  end

endmodule

// File: tb/tb_lin_sched.sv
// Scoreboard bench for lin_sched: directed scenarios push expected
// start/ok/timeout events; a negedge monitor pops and compares them.
module tb_lin_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] num = '0;
  logic       we = 1'b0;
  logic [2:0] addr = '0;
  logic [5:0] cpid = '0;
  logic [15:0] clen = '0;
  logic       busy = 1'b0;
  logic       resp = 1'b0;

  logic       s_start;
  logic [5:0] s_pid;
  logic [2:0] s_idx;
  logic       s_ok;
  logic       s_to;
  logic       s_act;

  lin_sched #(.N_SLOTS(8), .LEN_W(16), .MIN_LEN(32)) dut (
    .sys_clk      (clk),
    .rst          (rst),
    .en           (en),
    .num_slots    (num),
    .cfg_we       (we),
    .cfg_addr     (addr),
    .cfg_pid      (cpid),
    .cfg_len      (clen),
    .comm_busy    (busy),
    .resp_tx_done (resp),
    .start        (s_start),
    .pid          (s_pid),
    .slot_idx     (s_idx),
    .frame_ok     (s_ok),
    .frame_timeout(s_to),
    .sched_active (s_act)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int kind;
    int cyc;
    int pid;
  } ev_t;
  ev_t q[$];

  // kind: 0 start, 1 frame_ok, 2 frame_timeout
  task automatic exp_ev(input int k, input int c, input int p);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.pid  = p;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic pop_chk(input int k, input int p);
    ev_t e;
    n_tests++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL event: unexpected kind %0d at cycle %0d, want none",
               k, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.cyc != cyc || (k == 0 && e.pid != p)) begin
        n_fail++;
        $display("FAIL event: got kind %0d cyc %0d pid %0h, want kind %0d cyc %0d pid %0h",
                 k, cyc, p, e.kind, e.cyc, e.pid);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("ok_to_excl", int'(s_ok & s_to), 0);
      if (s_start) pop_chk(0, int'(s_pid));
      if (s_ok)    pop_chk(1, 0);
      if (s_to)    pop_chk(2, 0);
    end
  end

  task automatic step_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int a, input int p, input int l);
    we   = 1'b1;
    addr = 3'(a);
    cpid = 6'(p);
    clen = 16'(l);
    step_to(cyc + 1);
    we   = 1'b0;
  endtask

  task automatic pulse(input int c);
    step_to(c);
    resp = 1'b1;
    step_to(c + 1);
    resp = 1'b0;
  endtask

  initial begin
    int k;
    int t;
    int t6;
    #2;
    chk("rst_outputs", int'({s_start, s_pid, s_idx, s_ok, s_to, s_act}), 0);
    step_to(2);
    rst = 1'b0;

    // Two-entry table, response 40 cycles into each slot
    wr(0, 'h10, 100);
    wr(1, 'h21, 200);
    k = cyc; num = 4'd2; en = 1'b1; t = k + 1;
    exp_ev(0, t,       'h10); exp_ev(1, t + 41,  0);
    exp_ev(0, t + 100, 'h21); exp_ev(1, t + 141, 0);
    exp_ev(0, t + 300, 'h10); exp_ev(1, t + 341, 0);
    exp_ev(0, t + 400, 'h21); exp_ev(1, t + 441, 0);
    pulse(t + 40);
    step_to(t + 101);
    chk("s1_idx1", int'(s_idx), 1);
    pulse(t + 140);
    step_to(t + 150);
    chk("s1_pid_hold", int'(s_pid), 'h21);
    pulse(t + 340);
    step_to(t + 420);
    en = 1'b0;
    pulse(t + 440);
    step_to(t + 599);
    chk("s1_active_last", int'(s_act), 1);
    step_to(t + 600);
    chk("s1_active_off", int'(s_act), 0);

    // Timeout every 64 cycles, no responder
    step_to(cyc + 3);
    wr(0, 'h05, 64);
    num = 4'd1;
    k = cyc; en = 1'b1; t = k + 1;
    exp_ev(0, t,       'h05); exp_ev(2, t + 63,  0);
    exp_ev(0, t + 64,  'h05); exp_ev(2, t + 127, 0);
    exp_ev(0, t + 128, 'h05); exp_ev(2, t + 191, 0);
    step_to(t + 150);
    en = 1'b0;
    step_to(t + 192);
    chk("s2_active_off", int'(s_act), 0);

    // Busy hold-off, then MIN_LEN clamp with response in last slot cycle
    step_to(cyc + 3);
    wr(0, 'h3A, 10);
    k = cyc; busy = 1'b1; en = 1'b1; t = k + 51;
    exp_ev(0, t,      'h3A);
    exp_ev(0, t + 32, 'h3A); exp_ev(1, t + 32, 0);
    exp_ev(1, t + 64, 0);
    step_to(k + 20);
    chk("s3_busy_nostart", int'(s_start), 0);
    chk("s3_busy_active", int'(s_act), 1);
    step_to(k + 51);
    busy = 1'b0;
    pulse(t + 31);
    step_to(t + 40);
    en = 1'b0;
    pulse(t + 63);
    step_to(t + 64);
    chk("s3_active_off", int'(s_act), 0);

    // Shrinking num_slots while on the last slot wraps to 0
    step_to(cyc + 3);
    wr(0, 1, 40); wr(1, 2, 40); wr(2, 3, 40); wr(3, 4, 40);
    num = 4'd4;
    k = cyc; en = 1'b1; t = k + 1;
    exp_ev(0, t,       1); exp_ev(2, t + 39,  0);
    exp_ev(0, t + 40,  2); exp_ev(2, t + 79,  0);
    exp_ev(0, t + 80,  3); exp_ev(2, t + 119, 0);
    exp_ev(0, t + 120, 4); exp_ev(2, t + 159, 0);
    exp_ev(0, t + 160, 1); exp_ev(2, t + 199, 0);
    exp_ev(0, t + 200, 2); exp_ev(2, t + 239, 0);
    step_to(t + 130);
    chk("s4_idx3", int'(s_idx), 3);
    num = 4'd2;
    step_to(t + 161);
    chk("s4_wrap_idx0", int'(s_idx), 0);
    step_to(t + 210);
    en = 1'b0;
    step_to(t + 240);
    chk("s4_active_off", int'(s_act), 0);

    // Reset in WAIT_RESP, then the table must read back as zero
    step_to(cyc + 3);
    wr(0, 'h11, 100);
    num = 4'd1;
    k = cyc; en = 1'b1; t = k + 1;
    exp_ev(0, t, 'h11);
    step_to(t + 20);
    rst = 1'b1;
    en  = 1'b0;
    #1;
    chk("s5_rst_outputs",
        int'({s_start, s_pid, s_idx, s_ok, s_to, s_act}), 0);
    step_to(t + 22);
    rst = 1'b0;
    step_to(t + 25);
    en = 1'b1; t6 = t + 26;
    exp_ev(0, t6, 0); exp_ev(2, t6 + 31, 0);
    step_to(t6 + 5);
    en = 1'b0;
    chk("s5_pid_zero", int'(s_pid), 0);
    step_to(t6 + 40);
    chk("s5_active_off", int'(s_act), 0);
    chk("queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
